idma_backend_arbiter: RTL and testbench

// - Shares one iDMA backend between NumReq independent job sources (reg frontends, nd-midends).
// - Round-robin arbitrates 1D burst requests into a registered output stage that drives the backend request port.
// - Routes in-order backend responses back to the issuing requester as a done/error pulse.
// - Sits between the per-source job FIFOs and idma_backend; exports per-source busy for frontend idle logic.

---
 rtl/idma_backend_arbiter.sv | 154 +++++++++++++++
 tb/tb_idma_backend_arbiter.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idma_backend_arbiter.sv
// idma_backend_arbiter: round-robin sharing of one iDMA backend
// between NumReq job sources, with in-order response routing.
module idma_backend_arbiter #(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned ReqWidth       = 128,
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned IdxWidth       = $clog2(NumReq),
  parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NumReq-1:0]          en_i,
  input  logic [NumReq-1:0]          req_valid_i,
  output logic [NumReq-1:0]          req_ready_o,
  input  logic [NumReq*ReqWidth-1:0] req_data_i,
  output logic [ReqWidth-1:0]        be_req_o,
  output logic                       be_valid_o,
  input  logic                       be_ready_i,
  input  logic                       be_rsp_valid_i,
  input  logic                       be_rsp_error_i,
  output logic                       be_rsp_ready_o,
  output logic [NumReq-1:0]          done_o,
  output logic [NumReq-1:0]          error_o,
  output logic [NumReq-1:0]          busy_o,
  output logic [CntWidth-1:0]        outstanding_o,
  output logic                       idle_o
);

  localparam int unsigned PtrWidth = $clog2(MaxOutstanding);

  typedef enum logic {EMPTY, HOLD} state_e;

  state_e                state_q, state_d;
  logic [ReqWidth-1:0]   be_req_q, be_req_d;
  logic [IdxWidth-1:0]   rr_q, rr_d;
  logic [IdxWidth-1:0]   win;
  logic                  found;
  logic                  can_grant;
  logic                  grant;
  logic                  rsp_fire;
  logic [NumReq-1:0]     cand;
  logic [IdxWidth-1:0]   fifo_q [MaxOutstanding];
  logic [PtrWidth-1:0]   wptr_q, rptr_q;
  logic [IdxWidth-1:0]   head;
  logic [CntWidth-1:0]   out_q, out_d;
  logic [CntWidth-1:0]   cnt_q [NumReq];
  logic [CntWidth-1:0]   cnt_d [NumReq];
  logic [NumReq-1:0]     done_q, done_d;
  logic [NumReq-1:0]     error_q, error_d;

  assign cand      = req_valid_i & en_i;
  assign can_grant = ((state_q == EMPTY) ||
                      ((state_q == HOLD) && be_ready_i)) &&
                     (out_q < CntWidth'(MaxOutstanding));
  assign grant     = can_grant && found;
  assign head      = fifo_q[rptr_q];
  assign rsp_fire  = be_rsp_valid_i && (out_q != '0);

  // Round-robin pick: first candidate at or after the pointer.
  always_comb begin
    int unsigned j;
    found = 1'b0;
    win   = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      j = 32'(rr_q) + i;
      if (j >= NumReq) j = j - NumReq;
      if (!found && cand[IdxWidth'(j)]) begin
        found = 1'b1;
        win   = IdxWidth'(j);
      end
    end
  end

  // Output stage next state, pointer advance, grant vector.
  always_comb begin
    state_d     = state_q;
    be_req_d    = be_req_q;
    rr_d        = rr_q;
    req_ready_o = '0;
    if (grant) begin
      state_d     = HOLD;
      be_req_d    = req_data_i[win*ReqWidth +: ReqWidth];
      req_ready_o = NumReq'(1) << win;
      rr_d        = (win == IdxWidth'(NumReq - 1)) ?
                    '0 : win + IdxWidth'(1);
    end else if ((state_q == HOLD) && be_ready_i) begin
      state_d = EMPTY;
    end
  end

  // Tracking counters and completion pulses.
  always_comb begin
    out_d   = out_q;
    done_d  = '0;
    error_d = '0;
    if (grant && !rsp_fire) out_d = out_q + CntWidth'(1);
    if (!grant && rsp_fire) out_d = out_q - CntWidth'(1);
    if (rsp_fire) begin
      done_d  = NumReq'(1) << head;
      error_d = be_rsp_error_i ? done_d : '0;
    end
    for (int k = 0; k < NumReq; k++) begin
      cnt_d[k] = cnt_q[k];
      if (grant && (win == IdxWidth'(k)))
        cnt_d[k] = cnt_d[k] + CntWidth'(1);
      if (rsp_fire && (head == IdxWidth'(k)))
        cnt_d[k] = cnt_d[k] - CntWidth'(1);
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= EMPTY;
      be_req_q <= '0;
      rr_q     <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      out_q    <= '0;
      done_q   <= '0;
      error_q  <= '0;
      for (int k = 0; k < NumReq; k++) cnt_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      be_req_q <= be_req_d;
      rr_q     <= rr_d;
      out_q    <= out_d;
      done_q   <= done_d;
      error_q  <= error_d;
      for (int k = 0; k < NumReq; k++) cnt_q[k] <= cnt_d[k];
      if (grant)    wptr_q <= wptr_q + PtrWidth'(1);
      if (rsp_fire) rptr_q <= rptr_q + PtrWidth'(1);
    end
  end

  // ID FIFO storage; contents are don't-care while empty.
  always_ff @(posedge clk_i) begin
    if (grant) fifo_q[wptr_q] <= win;
  end

  // Per-requester busy flags.
  always_comb begin
    for (int k = 0; k < NumReq; k++) busy_o[k] = (cnt_q[k] != '0);
  end

  assign be_req_o       = be_req_q;
  assign be_valid_o     = (state_q == HOLD);
  assign be_rsp_ready_o = (out_q != '0);
  assign done_o         = done_q;
  assign error_o        = error_q;
  assign outstanding_o  = out_q;
  assign idle_o         = (out_q == '0) && (state_q == EMPTY);

endmodule

// File: tb/tb_idma_backend_arbiter.sv
// tb_idma_backend_arbiter: directed scenarios for the
// backend arbiter with hand-computed expectations.
module tb_idma_backend_arbiter;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [3:0]   en_i = 4'b1111;
  logic [3:0]   req_valid_i = '0;
  logic [3:0]   req_ready_o;
  logic [511:0] req_data_i = '0;
  logic [127:0] be_req_o;
  logic         be_valid_o;
  logic         be_ready_i = 1'b0;
  logic         be_rsp_valid_i = 1'b0;
  logic         be_rsp_error_i = 1'b0;
  logic         be_rsp_ready_o;
  logic [3:0]   done_o;
  logic [3:0]   error_o;
  logic [3:0]   busy_o;
  logic [3:0]   outstanding_o;
  logic         idle_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  idma_backend_arbiter dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .en_i           (en_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_data_i     (req_data_i),
    .be_req_o       (be_req_o),
    .be_valid_o     (be_valid_o),
    .be_ready_i     (be_ready_i),
    .be_rsp_valid_i (be_rsp_valid_i),
    .be_rsp_error_i (be_rsp_error_i),
    .be_rsp_ready_o (be_rsp_ready_o),
    .done_o         (done_o),
    .error_o        (error_o),
    .busy_o         (busy_o),
    .outstanding_o  (outstanding_o),
    .idle_o         (idle_o)
  );

  function automatic logic [127:0] dat(int k);
    return {4{32'hCAFE_0000 + 32'(k * 17 + 3)}};
  endfunction

  // Backend protocol: no response while the only job is still held.
  always @(negedge clk_i) begin
    if (!rst_i && be_rsp_valid_i && be_rsp_ready_o &&
        outstanding_o == 4'd1 && be_valid_o) begin
      errors++;
      $display("FAIL rsp_during_hold: rsp with only job held");
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i          = 1'b1;
    en_i           = 4'b1111;
    req_valid_i    = '0;
    be_ready_i     = 1'b0;
    be_rsp_valid_i = 1'b0;
    be_rsp_error_i = 1'b0;
    step();
    step();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (be_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b want 0", be_valid_o);
    end
    checks++;
    if (idle_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle: got %b want 1", idle_o);
    end
    checks++;
    if ({done_o, error_o, busy_o, outstanding_o} !== 16'h0) begin
      errors++;
      $display("FAIL reset_zero: got %h want 0",
               {done_o, error_o, busy_o, outstanding_o});
    end
    checks++;
    if ({be_rsp_ready_o, req_ready_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b want 0",
               {be_rsp_ready_o, req_ready_o});
    end
  endtask

  task automatic test_single();
    do_reset();
    be_ready_i  = 1'b1;
    req_valid_i = 4'b0001;
    #1;
    checks++;
    if (req_ready_o !== 4'b0001) begin
      errors++;
      $display("FAIL single_grant: got %b want 0001", req_ready_o);
    end
    step();
    req_valid_i = '0;
    #1;
    checks++;
    if (be_valid_o !== 1'b1 || be_req_o !== dat(0)) begin
      errors++;
      $display("FAIL single_out: valid %b req %h want 1 %h",
               be_valid_o, be_req_o, dat(0));
    end
    checks++;
    if (busy_o !== 4'b0001 || idle_o !== 1'b0) begin
      errors++;
      $display("FAIL single_busy: busy %b idle %b want 0001 0",
               busy_o, idle_o);
    end
    step();
    #1;
    checks++;
    if (be_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL single_accept: got %b want 0", be_valid_o);
    end
    step();
    step();
    be_rsp_valid_i = 1'b1;
    #1;
    checks++;
    if (be_rsp_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL single_rspready: got %b want 1", be_rsp_ready_o);
    end
    step();
    be_rsp_valid_i = 1'b0;
    #1;
    checks++;
    if (done_o !== 4'b0001 || error_o !== 4'b0000) begin
      errors++;
      $display("FAIL single_done: done %b err %b want 0001 0000",
               done_o, error_o);
    end
    checks++;
    if (idle_o !== 1'b1 || busy_o !== 4'b0) begin
      errors++;
      $display("FAIL single_idle: idle %b busy %b want 1 0000",
               idle_o, busy_o);
    end
    step();
    #1;
    checks++;
    if (done_o !== 4'b0000) begin
      errors++;
      $display("FAIL single_pulse: got %b want 0000", done_o);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    do_reset();
    be_ready_i  = 1'b1;
    req_valid_i = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      if (c == 2) be_rsp_valid_i = 1'b1;
      #1;
      exp = 4'b0001 << (c % 4);
      checks++;
      if (req_ready_o !== exp) begin
        errors++;
        $display("FAIL rr_grant c%0d: got %b want %b",
                 c, req_ready_o, exp);
      end
      if (c >= 1) begin
        checks++;
        if (be_valid_o !== 1'b1 || be_req_o !== dat((c - 1) % 4)) begin
          errors++;
          $display("FAIL rr_stream c%0d: valid %b req %h want %h",
                   c, be_valid_o, be_req_o, dat((c - 1) % 4));
        end
      end
      if (c >= 3) begin
        exp = 4'b0001 << ((c - 3) % 4);
        checks++;
        if (done_o !== exp) begin
          errors++;
          $display("FAIL rr_done c%0d: got %b want %b", c, done_o, exp);
        end
      end
      step();
    end
    req_valid_i = '0;
    step();
    step();
    step();
    step();
    be_rsp_valid_i = 1'b0;
    #1;
    checks++;
    if (outstanding_o !== 4'd0 || idle_o !== 1'b1) begin
      errors++;
      $display("FAIL rr_drain: out %0d idle %b want 0 1",
               outstanding_o, idle_o);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    be_ready_i  = 1'b0;
    req_valid_i = 4'b0001;
    #1;
    checks++;
    if (req_ready_o !== 4'b0001) begin
      errors++;
      $display("FAIL bp_grant: got %b want 0001", req_ready_o);
    end
    step();
    req_valid_i = 4'b0011;
    for (int c = 1; c <= 5; c++) begin
      #1;
      checks++;
      if (be_valid_o !== 1'b1 || be_req_o !== dat(0) ||
          req_ready_o !== 4'b0000) begin
        errors++;
        $display("FAIL bp_hold c%0d: valid %b ready %b req %h",
                 c, be_valid_o, req_ready_o, be_req_o);
      end
      step();
    end
    be_ready_i = 1'b1;
    #1;
    checks++;
    if (req_ready_o !== 4'b0010) begin
      errors++;
      $display("FAIL bp_accept_grant: got %b want 0010", req_ready_o);
    end
    step();
    req_valid_i = '0;
    #1;
    checks++;
    if (be_valid_o !== 1'b1 || be_req_o !== dat(1)) begin
      errors++;
      $display("FAIL bp_next: valid %b req %h want 1 %h",
               be_valid_o, be_req_o, dat(1));
    end
    step();
    be_rsp_valid_i = 1'b1;
    #1;
    checks++;
    if (outstanding_o !== 4'd2) begin
      errors++;
      $display("FAIL bp_out: got %0d want 2", outstanding_o);
    end
    step();
    #1;
    checks++;
    if (done_o !== 4'b0001) begin
      errors++;
      $display("FAIL bp_done0: got %b want 0001", done_o);
    end
    step();
    be_rsp_valid_i = 1'b0;
    #1;
    checks++;
    if (done_o !== 4'b0010 || idle_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_done1: done %b idle %b want 0010 1",
               done_o, idle_o);
    end
  endtask

  task automatic test_max_outstanding();
    logic [3:0] exp;
    int grants;
    grants = 0;
    do_reset();
    be_ready_i  = 1'b1;
    req_valid_i = 4'b0001;
    for (int c = 0; c < 12; c++) begin
      #1;
      exp = (c < 8) ? 4'b0001 : 4'b0000;
      if (req_ready_o != 4'b0) grants++;
      checks++;
      if (req_ready_o !== exp) begin
        errors++;
        $display("FAIL max_grant c%0d: got %b want %b",
                 c, req_ready_o, exp);
      end
      step();
    end
    checks++;
    if (grants != 8 || outstanding_o !== 4'd8) begin
      errors++;
      $display("FAIL max_count: grants %0d out %0d want 8 8",
               grants, outstanding_o);
    end
    be_rsp_valid_i = 1'b1;
    #1;
    checks++;
    if (req_ready_o !== 4'b0000 || be_rsp_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL max_same_cycle: ready %b rspr %b want 0000 1",
               req_ready_o, be_rsp_ready_o);
    end
    step();
    be_rsp_valid_i = 1'b0;
    #1;
    checks++;
    if (req_ready_o !== 4'b0001 || done_o !== 4'b0001) begin
      errors++;
      $display("FAIL max_regrant: ready %b done %b want 0001 0001",
               req_ready_o, done_o);
    end
    step();
    #1;
    checks++;
    if (req_ready_o !== 4'b0000 || outstanding_o !== 4'd8) begin
      errors++;
      $display("FAIL max_refull: ready %b out %0d want 0000 8",
               req_ready_o, outstanding_o);
    end
  endtask

  task automatic test_error();
    do_reset();
    be_ready_i  = 1'b1;
    req_valid_i = 4'b0100;
    #1;
    checks++;
    if (req_ready_o !== 4'b0100) begin
      errors++;
      $display("FAIL err_grant: got %b want 0100", req_ready_o);
    end
    step();
    req_valid_i = '0;
    #1;
    checks++;
    if (be_req_o !== dat(2) || busy_o !== 4'b0100) begin
      errors++;
      $display("FAIL err_issue: req %h busy %b want %h 0100",
               be_req_o, busy_o, dat(2));
    end
    step();
    req_valid_i    = 4'b0100;
    be_rsp_valid_i = 1'b1;
    be_rsp_error_i = 1'b1;
    #1;
    checks++;
    if (req_ready_o !== 4'b0100 || outstanding_o !== 4'd1) begin
      errors++;
      $display("FAIL err_both: ready %b out %0d want 0100 1",
               req_ready_o, outstanding_o);
    end
    step();
    req_valid_i    = '0;
    be_rsp_valid_i = 1'b0;
    be_rsp_error_i = 1'b0;
    #1;
    checks++;
    if (done_o !== 4'b0100 || error_o !== 4'b0100) begin
      errors++;
      $display("FAIL err_pulse: done %b err %b want 0100 0100",
               done_o, error_o);
    end
    checks++;
    if (outstanding_o !== 4'd1 || busy_o !== 4'b0100) begin
      errors++;
      $display("FAIL err_net: out %0d busy %b want 1 0100",
               outstanding_o, busy_o);
    end
    step();
    be_rsp_valid_i = 1'b1;
    step();
    be_rsp_valid_i = 1'b0;
    #1;
    checks++;
    if (done_o !== 4'b0100 || error_o !== 4'b0000 ||
        busy_o !== 4'b0000) begin
      errors++;
      $display("FAIL err_second: done %b err %b busy %b",
               done_o, error_o, busy_o);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    be_ready_i  = 1'b1;
    req_valid_i = 4'b0111;
    step();
    step();
    step();
    step();
    be_ready_i  = 1'b0;
    req_valid_i = '0;
    #1;
    checks++;
    if (outstanding_o !== 4'd4 || busy_o !== 4'b0111 ||
        be_req_o !== dat(0) || be_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: out %0d busy %b valid %b",
               outstanding_o, busy_o, be_valid_o);
    end
    rst_i          = 1'b1;
    be_rsp_valid_i = 1'b1;
    step();
    rst_i = 1'b0;
    #1;
    checks++;
    if (be_valid_o !== 1'b0 || be_req_o !== 128'h0 ||
        idle_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_held: valid %b idle %b want 0 1",
               be_valid_o, idle_o);
    end
    checks++;
    if ({outstanding_o, busy_o, done_o, be_rsp_ready_o} !== 13'h0) begin
      errors++;
      $display("FAIL mid_track: got %h want 0",
               {outstanding_o, busy_o, done_o, be_rsp_ready_o});
    end
    be_rsp_valid_i = 1'b0;
    req_valid_i    = 4'b1001;
    en_i           = 4'b1110;
    #1;
    checks++;
    if (req_ready_o !== 4'b1000) begin
      errors++;
      $display("FAIL mid_mask: got %b want 1000", req_ready_o);
    end
    en_i = 4'b1111;
    #1;
    checks++;
    if (req_ready_o !== 4'b0001) begin
      errors++;
      $display("FAIL mid_rr0: got %b want 0001", req_ready_o);
    end
    step();
    req_valid_i = '0;
    #1;
    checks++;
    if (done_o !== 4'b0000 || be_req_o !== dat(0)) begin
      errors++;
      $display("FAIL mid_after: done %b req %h", done_o, be_req_o);
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) req_data_i[k*128 +: 128] = dat(k);
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_max_outstanding();
    test_error();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
